// File: rtl/mult_seq_ctrl_if.sv
// Request, status and register-file port bundle for mult_seq_ctrl.
// master: sequencing logic plus register file (drives requests and read data).
// slave:  the multiply controller (drives register-file port and status).
interface mult_seq_ctrl_if;
    logic        start;
    logic [2:0]  src_m;
    logic [2:0]  src_q;
    logic [2:0]  dst;
    logic [15:0] rf_rdata;
    logic [2:0]  rf_addr;
    logic        rf_re;
    logic        rf_we;
    logic [15:0] rf_wdata;
    logic        busy;
    logic        done;
    logic [31:0] product;

    modport master (
        output start, src_m, src_q, dst, rf_rdata,
        input  rf_addr, rf_re, rf_we, rf_wdata, busy, done, product
    );

    modport slave (
        input  start, src_m, src_q, dst, rf_rdata,
        output rf_addr, rf_re, rf_we, rf_wdata, busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add 16x16 unsigned multiplier sequencing reads/writes on one register-file port.
// Latency: 21 cycles start-to-done; with MULT_EARLY_EXIT_EN defined, 5 + (index of highest multiplier bit + 1).
// Backpressure: none; start is sampled only in IDLE, requests while busy are dropped, not queued.
module mult_seq_ctrl (
    input  logic          CLK,
    input  logic          RST_N,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        LOAD_Q = 3'd2,
        MUL    = 3'd3,
        WR_LO  = 3'd4,
        WR_HI  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  src_m_r;
    logic [2:0]  src_q_r;
    logic [2:0]  dst_r;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [3:0]  cnt;
    logic [31:0] product_r;
    logic        mul_last;

    // Final MUL iteration: all 16 bits consumed, or (early exit) no set bits remain after this shift.
`ifdef MULT_EARLY_EXIT_EN
    assign mul_last = (cnt == 4'd15) || (mplier[15:1] == 15'd0);
`else
    assign mul_last = (cnt == 4'd15);
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD_M;
            LOAD_M:  state_nxt = LOAD_Q;
            LOAD_Q:  state_nxt = MUL;
            MUL:     if (mul_last) state_nxt = WR_LO;
            WR_LO:   state_nxt = WR_HI;
            WR_HI:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand latching, shift-and-add iterations, product capture on entry to DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_m_r   <= 3'd0;
            src_q_r   <= 3'd0;
            dst_r     <= 3'd0;
            mcand     <= 32'd0;
            mplier    <= 16'd0;
            acc       <= 32'd0;
            cnt       <= 4'd0;
            product_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        src_m_r <= bus.src_m;
                        src_q_r <= bus.src_q;
                        dst_r   <= bus.dst;
                        acc     <= 32'd0;
                    end
                end
                LOAD_M: begin
                    mcand <= {16'd0, bus.rf_rdata};
                end
                LOAD_Q: begin
                    mplier <= bus.rf_rdata;
                    cnt    <= 4'd0;
                end
                MUL: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[15:1]};
                    cnt    <= cnt + 4'd1;
                end
                WR_HI: begin
                    // acc is final here, so product is already valid in the DONE cycle.
                    product_r <= acc;
                end
                default: begin
                end
            endcase
        end
    end

    // Register-file port and status outputs, decoded from state so reset clears them at once.
    always_comb begin
        bus.rf_addr  = 3'd0;
        bus.rf_re    = 1'b0;
        bus.rf_we    = 1'b0;
        bus.rf_wdata = 16'd0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (state)
            LOAD_M: begin
                bus.rf_addr = src_m_r;
                bus.rf_re   = 1'b1;
                bus.busy    = 1'b1;
            end
            LOAD_Q: begin
                bus.rf_addr = src_q_r;
                bus.rf_re   = 1'b1;
                bus.busy    = 1'b1;
            end
            MUL: begin
                bus.busy = 1'b1;
            end
            WR_LO: begin
                bus.rf_addr  = dst_r;
                bus.rf_we    = 1'b1;
                bus.rf_wdata = acc[15:0];
                bus.busy     = 1'b1;
            end
            WR_HI: begin
                bus.rf_addr  = dst_r + 3'd1;
                bus.rf_we    = 1'b1;
                bus.rf_wdata = acc[31:16];
                bus.busy     = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.product = product_r;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural 8x16 register file.
// Vector table covers plain, squaring, wrap and zero cases; hand sequences cover ignored starts and mid-op reset.
module tb_mult_seq_ctrl;
    logic CLK;
    logic RST_N;
    mult_seq_ctrl_if bus ();

    mult_seq_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] rf [8];
    logic        pl_we;
    logic [2:0]  pl_addr;
    logic [15:0] pl_dat;
    int          wr_cnt;

    assign bus.rf_rdata = rf[bus.rf_addr];

    // Register file: DUT writes, plus bench preload while the DUT is idle.
    always @(posedge CLK) begin
        if (bus.rf_we) begin
            rf[bus.rf_addr] <= bus.rf_wdata;
            wr_cnt <= wr_cnt + 1;
        end else if (pl_we) begin
            rf[pl_addr] <= pl_dat;
        end
    end

    typedef struct {
        logic [2:0]  m_addr;
        logic [2:0]  q_addr;
        logic [2:0]  dst;
        logic [15:0] m_val;
        logic [15:0] q_val;
        logic [31:0] exp_prod;
        int          lat;
        int          lat_ee;
    } vec_t;

    vec_t vt [6];
    int   n_tests;
    int   n_fail;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        tick();
        pl_we   = 1'b0;
    endtask

    function automatic int exp_latency(input vec_t v);
`ifdef MULT_EARLY_EXIT_EN
        return v.lat_ee;
`else
        return v.lat;
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          w0;
        logic [2:0]  d1;
        d1 = v.dst + 3'd1;
        preload(v.m_addr, v.m_val);
        preload(v.q_addr, v.q_val);
        w0 = wr_cnt;
        bus.src_m = v.m_addr;
        bus.src_q = v.q_addr;
        bus.dst   = v.dst;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("load_m_re", {31'd0, bus.rf_re}, 32'd1);
        check("load_m_addr", {29'd0, bus.rf_addr}, {29'd0, v.m_addr});
        tick();
        check("load_q_addr", {29'd0, bus.rf_addr}, {29'd0, v.q_addr});
        cyc = 2;
        while (!bus.done && cyc < 60) begin
            tick();
            cyc++;
        end
        check("latency", cyc, exp_latency(v));
        check("product", bus.product, v.exp_prod);
        tick();
        check("done_pulse_len", {31'd0, bus.done}, 32'd0);
        check("busy_after", {31'd0, bus.busy}, 32'd0);
        check("rf_lo", {16'd0, rf[v.dst]}, {16'd0, v.exp_prod[15:0]});
        check("rf_hi", {16'd0, rf[d1]}, {16'd0, v.exp_prod[31:16]});
        check("write_count", wr_cnt - w0, 2);
    endtask

    initial begin
        int cyc;
        int dones;
        int w0;

        vt[0] = '{3'd1, 3'd2, 3'd4, 16'h0003, 16'h0005, 32'h0000_000F, 21, 8};
        vt[1] = '{3'd0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 21, 21};
        vt[2] = '{3'd3, 3'd6, 3'd7, 16'h1234, 16'h0100, 32'h0012_3400, 21, 14};
        vt[3] = '{3'd2, 3'd3, 3'd5, 16'hABCD, 16'h0000, 32'h0000_0000, 21, 6};
        vt[4] = '{3'd4, 3'd5, 3'd2, 16'hFFFF, 16'h0001, 32'h0000_FFFF, 21, 6};
        vt[5] = '{3'd6, 3'd1, 3'd3, 16'h0003, 16'h8000, 32'h0001_8000, 21, 21};

        n_tests   = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        pl_we     = 1'b0;
        pl_addr   = 3'd0;
        pl_dat    = 16'd0;
        bus.start = 1'b0;
        bus.src_m = 3'd0;
        bus.src_q = 3'd0;
        bus.dst   = 3'd0;
        for (int i = 0; i < 8; i++) rf[i] = 16'd0;
        RST_N = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("rst_re", {31'd0, bus.rf_re}, 32'd0);
        check("rst_addr", {29'd0, bus.rf_addr}, 32'd0);
        check("rst_wdata", {16'd0, bus.rf_wdata}, 32'd0);
        check("rst_product", bus.product, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(vt[i]);
        end

        // Starts during an operation are dropped; a start in the cycle after DONE is taken.
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        preload(3'd6, 16'hBEEF);
        preload(3'd4, 16'h1111);
        w0 = wr_cnt;
        dones = 0;
        bus.src_m = 3'd1;
        bus.src_q = 3'd2;
        bus.dst   = 3'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 60) begin
            bus.start = (cyc == 4);
            tick();
            cyc++;
        end
        check("ign_latency", cyc, exp_latency(vt[0]));
        if (bus.done) dones++;
        bus.start = 1'b1;
        bus.dst   = 3'd6;
        tick();
        if (bus.done) dones++;
        check("ign_idle_busy", {31'd0, bus.busy}, 32'd0);
        check("ign_done_count", dones, 1);
        check("ign_write_count", wr_cnt - w0, 2);
        check("ign_rf_lo", {16'd0, rf[4]}, 32'h0000_000F);
        tick();
        bus.start = 1'b0;
        check("restart_busy", {31'd0, bus.busy}, 32'd1);
        check("restart_addr", {29'd0, bus.rf_addr}, 32'd1);

        // Reset in MUL (cycle 10 of the restarted op) clears outputs immediately, no write follows.
        for (int i = 1; i < 10; i++) tick();
        check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
        w0 = wr_cnt;
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        check("mid_rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("mid_rst_product", bus.product, 32'd0);
        for (int i = 0; i < 14; i++) tick();
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        tick();
        check("mid_rst_no_write", wr_cnt - w0, 0);
        check("mid_rst_dst_kept", {16'd0, rf[6]}, 32'h0000_BEEF);
        check("post_rst_idle", {31'd0, bus.busy}, 32'd0);

        run_vec(vt[2]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
